// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle control unit.
//   - FSM state encoding (FETCH=0 .. WB=4, TRAP=7)
//   - RV32 major opcodes handled by the controller
//   - instruction class, ALUop and immSel encodings
//   - classify(): maps a 7-bit opcode to its instruction class
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_B    = 2'b10,
    IMM_NONE = 2'b11
  } imm_sel_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_RTYPE:  return CLS_R;
      OP_IALU:   return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational ALU operation select.
// Ports:
//   cls_i     instruction class of the latched instruction
//   funct3_i  IR[14:12]
//   bit30_i   IR[30] (selects SUB for R-type funct3=000)
//   aluop_o   ALU operation code
// Loads/stores always add (address generation), branches always subtract
// (compare via zero flag). Unsupported funct3 falls back to ADD.
module alu_decode
  import ctrl_pkg::*;
(
  input  op_class_e  cls_i,
  input  logic [2:0] funct3_i,
  input  logic       bit30_i,
  output alu_op_e    aluop_o
);

  always_comb begin
    aluop_o = ALU_ADD;
    case (cls_i)
      CLS_BRANCH: aluop_o = ALU_SUB;
      CLS_R, CLS_I: begin
        case (funct3_i)
          // IR[30] is part of the immediate for I-ALU, so only R-type uses it here.
          3'b000:  aluop_o = (cls_i == CLS_R && bit30_i) ? ALU_SUB : ALU_ADD;
          3'b111:  aluop_o = ALU_AND;
          3'b110:  aluop_o = ALU_OR;
          3'b100:  aluop_o = ALU_XOR;
          3'b010:  aluop_o = ALU_SLT;
          3'b001:  aluop_o = ALU_SLL;
          3'b101:  aluop_o = ALU_SRL;
          default: aluop_o = ALU_ADD;
        endcase
      end
      default: aluop_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FSM controller for the single-cycle datapath.
// Sequences each instruction FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Optional build macro CTRL_PERF_EN adds cycle_cnt / retired_cnt counters.
// Ports:
//   clk, rst (async, active-low)
//   instruction  instruction word, latched in FETCH
//   zero         ALU zero flag, used for branch resolution in EXEC
//   status       ALU status flags, captured in EXEC for debug only
//   mem_ready    data-memory handshake, holds MEM while low
//   PCsrc, ALUsrc, memReadWrite, memToReg, RegWrite, immSel, ALUop
//                datapath control strobes
//   pc_en        one-cycle PC advance enable (instruction retire)
//   trap         sticky illegal-opcode flag
//   state_o      current FSM state
//   cycle_cnt, retired_cnt  performance counters (CTRL_PERF_EN only)
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int IW = 32
`ifdef CTRL_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction,
  input  logic          zero,
  input  logic [3:0]    status,
  input  logic          mem_ready,
  output logic          PCsrc,
  output logic          ALUsrc,
  output logic          memReadWrite,
  output logic          memToReg,
  output logic          RegWrite,
  output logic [1:0]    immSel,
  output logic [2:0]    ALUop,
  output logic          pc_en,
  output logic          trap,
  output logic [2:0]    state_o
`ifdef CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] retired_cnt
`endif
);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q;
  logic [3:0]    status_q;
  op_class_e     cls;
  alu_op_e       alu_op;
  logic [2:0]    funct3;
  logic          alu_phase;

  assign cls    = classify(ir_q[6:0]);
  assign funct3 = ir_q[14:12];

  alu_decode u_alu_decode (
    .cls_i    (cls),
    .funct3_i (funct3),
    .bit30_i  (ir_q[30]),
    .aluop_o  (alu_op)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q     <= '0;
      status_q <= '0;
    end else begin
      if (state_q == ST_FETCH) ir_q <= instruction;
      if (state_q == ST_EXEC)  status_q <= status;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = (cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CLS_BRANCH:          state_d = ST_FETCH;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // ALU-side controls stay valid from EXEC through WB so the combinational
  // datapath keeps producing the same result for address/write-back.
  assign alu_phase = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

  always_comb begin
    PCsrc        = 1'b0;
    ALUsrc       = 1'b0;
    memReadWrite = 1'b0;
    memToReg     = 1'b0;
    RegWrite     = 1'b0;
    immSel       = IMM_NONE;
    ALUop        = ALU_ADD;
    pc_en        = 1'b0;
    trap         = 1'b0;
    if (alu_phase) begin
      ALUop  = alu_op;
      ALUsrc = (cls == CLS_I) || (cls == CLS_LOAD) || (cls == CLS_STORE);
      case (cls)
        CLS_I, CLS_LOAD: immSel = IMM_I;
        CLS_STORE:       immSel = IMM_S;
        CLS_BRANCH:      immSel = IMM_B;
        default:         immSel = IMM_NONE;
      endcase
    end
    case (state_q)
      ST_EXEC: begin
        if (cls == CLS_BRANCH) begin
          pc_en = 1'b1;
          case (funct3)
            3'b000:  PCsrc = zero;
            3'b001:  PCsrc = ~zero;
            default: PCsrc = 1'b0;
          endcase
        end
      end
      ST_MEM: begin
        memReadWrite = (cls == CLS_STORE);
        // A store retires in the cycle memory completes, with no WB stage.
        pc_en        = (cls == CLS_STORE) && mem_ready;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        memToReg = (cls == CLS_LOAD);
        pc_en    = 1'b1;
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

`ifdef CTRL_PERF_EN
  logic [PERF_W-1:0] cycle_cnt_q, retired_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (state_q != ST_TRAP) cycle_cnt_q <= cycle_cnt_q + PERF_W'(1);
      if (pc_en) retired_cnt_q <= retired_cnt_q + PERF_W'(1);
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`endif

  // Fields of IR not consumed by the controller, plus the debug status capture.
  logic unused_bits;
  assign unused_bits = ^{ir_q[IW-1:31], ir_q[29:15], ir_q[11:7], status_q};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// The stimulus side expands each instruction into its per-cycle expected
// control vector and queues it; the monitor pops one vector per cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = '0;
  logic        zero = 1'b0;
  logic [3:0]  status = '0;
  logic        mem_ready = 1'b1;
  logic        PCsrc, ALUsrc, memReadWrite, memToReg, RegWrite, pc_en, trap;
  logic [1:0]  immSel;
  logic [2:0]  ALUop, state_o;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.IW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .zero         (zero),
    .status       (status),
    .mem_ready    (mem_ready),
    .PCsrc        (PCsrc),
    .ALUsrc       (ALUsrc),
    .memReadWrite (memReadWrite),
    .memToReg     (memToReg),
    .RegWrite     (RegWrite),
    .immSel       (immSel),
    .ALUop        (ALUop),
    .pc_en        (pc_en),
    .trap         (trap),
    .state_o      (state_o)
`ifdef CTRL_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .retired_cnt  (retired_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcsrc;
    logic       alusrc;
    logic       memrw;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] imm;
    logic [2:0] aluop;
    logic       pc_en;
    logic       trap;
  } vec_t;

  typedef struct {
    vec_t v;
    bit   rc;  // reset held low through this cycle
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  // ---------------- reference model ----------------
  // kinds: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 illegal
  function automatic int kind_of(input logic [6:0] opc);
    case (opc)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 5;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input int k, input logic [31:0] ins);
    // funct3 -> op: ADD, SLL, SLT, (ADD), XOR, SRL, OR, AND
    logic [2:0] tbl [8] = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    logic [2:0] f3;
    f3 = ins[14:12];
    if (k == 2 || k == 3) return 3'd0;
    if (k == 4) return 3'd1;
    if (k == 0 && f3 == 3'd0 && ins[30]) return 3'd1;
    return tbl[f3];
  endfunction

  function automatic vec_t idle(input int unsigned st);
    vec_t v;
    v     = '0;
    v.st  = 3'(st);
    v.imm = 2'b11;
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  task automatic cyc(input vec_t v, input bit rc, input logic r, input logic z,
                     input logic mr, input logic [31:0] ins);
    sb_t s;
    @(posedge clk);
    #1;
    rst         = r;
    zero        = z;
    mem_ready   = mr;
    instruction = ins;
    status      = 4'($urandom);
    s.v  = v;
    s.rc = rc;
    sb.push_back(s);
  endtask

  task automatic reset_cycle();
    cyc(idle(0), 1'b1, 1'b0, rb(), rb(), $urandom);
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic z,
                           input int unsigned waits, input bit abort_wb);
    int         k;
    vec_t       base, v;
    logic       mr;
    logic [2:0] f3;
    k  = kind_of(ins[6:0]);
    f3 = ins[14:12];
    cyc(idle(0), 1'b0, 1'b1, rb(), rb(), ins);
    cyc(idle(1), 1'b0, 1'b1, rb(), rb(), $urandom);
    if (k == 5) begin
      v = idle(7);
      v.trap = 1'b1;
      for (int unsigned i = 0; i < 12; i++) cyc(v, 1'b0, 1'b1, rb(), rb(), $urandom);
      return;
    end
    base        = idle(2);
    base.alusrc = (k == 1 || k == 2 || k == 3);
    base.imm    = (k == 0) ? 2'b11 : (k == 3) ? 2'b01 : (k == 4) ? 2'b10 : 2'b00;
    base.aluop  = alu_of(k, ins);
    v = base;
    if (k == 4) begin
      v.pc_en = 1'b1;
      v.pcsrc = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0;
    end
    cyc(v, 1'b0, 1'b1, z, rb(), $urandom);
    if (k == 4) return;
    if (k == 2 || k == 3) begin
      for (int unsigned i = 0; i <= waits; i++) begin
        mr      = (i == waits);
        v       = base;
        v.st    = 3'd3;
        v.memrw = (k == 3);
        v.pc_en = (k == 3) && mr;
        cyc(v, 1'b0, 1'b1, rb(), mr, $urandom);
      end
      if (k == 3) return;
    end
    if (abort_wb) begin
      reset_cycle();
    end else begin
      v          = base;
      v.st       = 3'd4;
      v.regwrite = 1'b1;
      v.memtoreg = (k == 2);
      v.pc_en    = 1'b1;
      cyc(v, 1'b0, 1'b1, rb(), rb(), $urandom);
    end
  endtask

  function automatic logic [31:0] rand_legal();
    logic [6:0]  ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    logic [31:0] ins;
    ins      = $urandom;
    ins[6:0] = ops[$urandom_range(4, 0)];
    if (ins[6:0] == 7'b1100011 && $urandom_range(1, 0) == 1) ins[14:13] = 2'b00;
    return ins;
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] ins;
    ins      = $urandom;
    ins[6:0] = 7'h7F;
    for (int unsigned i = 0; i < 100; i++) begin
      if (kind_of(ins[6:0]) != 5) ins[6:0] = 7'($urandom);
    end
    if (kind_of(ins[6:0]) != 5) ins[6:0] = 7'h7F;
    return ins;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    sb_t  e;
    vec_t a;
`ifdef CTRL_PERF_EN
    int unsigned mc = 0, mret = 0;
`endif
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e          = sb.pop_front();
        a.st       = state_o;
        a.pcsrc    = PCsrc;
        a.alusrc   = ALUsrc;
        a.memrw    = memReadWrite;
        a.memtoreg = memToReg;
        a.regwrite = RegWrite;
        a.imm      = immSel;
        a.aluop    = ALUop;
        a.pc_en    = pc_en;
        a.trap     = trap;
        total++;
        if (a !== e.v) begin
          bad++;
          $display("FAIL ctrl @%0t actual=%04h required=%04h (st,pcsrc,alusrc,memrw,memtoreg,regwr,imm,aluop,pc_en,trap)",
                   $time, a, e.v);
        end
`ifdef CTRL_PERF_EN
        if (e.rc) begin
          mc   = 0;
          mret = 0;
        end
        total++;
        if (cycle_cnt !== mc || retired_cnt !== mret) begin
          bad++;
          $display("FAIL perf @%0t actual cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                   $time, cycle_cnt, retired_cnt, mc, mret);
        end
        if (!e.rc) begin
          if (e.v.st != 3'd7) mc++;
          if (e.v.pc_en) mret++;
        end
`endif
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    reset_cycle();
    reset_cycle();
    run_instr(32'h002081B3, rb(), 0, 1'b0);  // ADD
    run_instr(32'h0000A183, rb(), 2, 1'b0);  // LW, memory stalls 2 cycles
    run_instr(32'h0030A023, rb(), 0, 1'b0);  // SW
    run_instr(32'h00208463, 1'b1, 0, 1'b0);  // BEQ taken
    run_instr(32'h00209463, 1'b1, 0, 1'b0);  // BNE not taken
    run_instr(32'h402081B3, rb(), 0, 1'b0);  // SUB
    run_instr(32'h4000D093, rb(), 0, 1'b0);  // SRLI with IR[30] set
    run_instr(32'h0000B1B3, rb(), 0, 1'b0);  // funct3=011 falls back to ADD
    for (int unsigned i = 0; i < 80; i++)
      run_instr(rand_legal(), rb(), $urandom_range(3, 0), 1'b0);
    run_instr(32'h002081B3, rb(), 0, 1'b1);  // reset during WB
    run_instr(32'h002081B3, rb(), 0, 1'b0);
    run_instr(32'h0000007F, rb(), 0, 1'b0);  // illegal -> TRAP
    reset_cycle();
    for (int unsigned i = 0; i < 30; i++)
      run_instr(rand_legal(), rb(), $urandom_range(3, 0), 1'b0);
    run_instr(rand_illegal(), rb(), 0, 1'b0);
    reset_cycle();
    run_instr(rand_legal(), rb(), 1, 1'b0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
